// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters.
// Ports: clk/reset_n, req/we/be/addr/din per requester, gnt/rvalid/rdata back,
// mem_* to BRAM; optional grant_cnt_o/stats_clr_i (SHARED_MEM_ARB_STATS_EN).
module shared_mem_arbiter #(
  parameter int NREQ       = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        we_i,
  input  logic [NREQ*DW/8-1:0]   be_i,
  input  logic [NREQ*AW-1:0]     addr_i,
  input  logic [NREQ*DW-1:0]     din_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        rvalid_o,
  output logic [DW-1:0]          rdata_o,
  output logic                   mem_en_o,
  output logic [DW/8-1:0]        mem_we_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [DW-1:0]          mem_din_o,
`ifdef SHARED_MEM_ARB_STATS_EN
  input  logic                   stats_clr_i,
  output logic [NREQ*16-1:0]     grant_cnt_o,
`endif
  input  logic [DW-1:0]          mem_dout_i
);

  localparam int BW = DW / 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int L  = RD_LATENCY;

  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic            en_q;
  logic [BW-1:0]   we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic [PW-1:0]   ptr_q;
  logic            rd_q;
  logic [PW-1:0]   own_q;

  // Read-return pipe: owner of each in-flight read, aligned to BRAM latency
  logic [L-1:0]    pv_q;
  logic [PW-1:0]   po_q [L];

  logic [NREQ-1:0] elig;
  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;
  logic [BW-1:0]   sel_be;
  logic            sel_we;

  // A requester holding gnt this cycle is masked so one
  // transaction is never granted twice.
  always_comb begin
    int j;
    j       = 0;
    elig    = req_i & ~gnt_q;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && elig[j]) begin
        win_vld = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  always_comb begin
    sel_addr = addr_i[int'(win_idx)*AW +: AW];
    sel_din  = din_i[int'(win_idx)*DW +: DW];
    sel_be   = be_i[int'(win_idx)*BW +: BW];
    sel_we   = we_i[win_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q  <= '0;
      en_q   <= 1'b0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      ptr_q  <= PW'(NREQ - 1);
      rd_q   <= 1'b0;
      own_q  <= '0;
    end else begin
      gnt_q <= '0;
      en_q  <= win_vld;
      we_q  <= '0;
      rd_q  <= 1'b0;
      if (win_vld) begin
        gnt_q[win_idx] <= 1'b1;
        ptr_q  <= win_idx;
        addr_q <= sel_addr;
        din_q  <= sel_din;
        own_q  <= win_idx;
        if (sel_we) we_q <= sel_be;
        else        rd_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q     <= '0;
      for (int i = 0; i < L; i++) po_q[i] <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      pv_q[0] <= rd_q;
      po_q[0] <= own_q;
      for (int i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
      end
      rvalid_q <= '0;
      if (pv_q[L-1]) begin
        rvalid_q[po_q[L-1]] <= 1'b1;
        rdata_q <= mem_dout_i;
      end
    end
  end

  assign gnt_o      = gnt_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign mem_en_o   = en_q;
  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_din_o  = din_q;

`ifdef SHARED_MEM_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // Clear takes precedence over a same-cycle grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (stats_clr_i)
          cnt_q[k] <= '0;
        else if (gnt_q[k] && cnt_q[k] != 16'hFFFF)
          cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NREQ; k++)
      grant_cnt_o[k*16 +: 16] = cnt_q[k];
  end
`endif

endmodule
